dlfloat_mul_pipe: RTL and testbench
===================================

DLFLOAT_MUL_PIPE -- requirements
Module: dlfloat_mul_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 6, giving the exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 9, giving the stored mantissa width (hidden 1 not stored); W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a, in_b  input  W each  operands, {sign, exp, mant}.
REQ-008 rnd_mode  input  1  sampled with operands; 0 = truncate, 1 = round-to-nearest-even (RNE).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_data  output  W  product.
REQ-012 out_flags  output  3  {nan, ovf, unf} for out_data; present only per REQ-030.

Function
REQ-013 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output); an unaccepted out_data/out_flags SHALL hold stable.
REQ-014 Pipeline: 3 stages (S1 classify + exponent sum, S2 mantissa multiply, S3 normalise/round/pack), each with a valid bit; latency exactly 3 cycles from acceptance to out_valid when not stalled.
REQ-015 A stage SHALL advance when its successor is empty or advancing; in_ready = !S1.valid | S1 advancing (combinational from out_ready); bubbles collapse; throughput 1/cycle.
REQ-016 Results SHALL leave in acceptance order; no drop, no duplication under any out_ready pattern.
REQ-017 Classification priority (first match wins), esum = ea+eb computed EXP_W+1 bits wide:
REQ-018 (1) either operand all-ones -> out = all-ones, nan=1.
REQ-019 (2) either operand exp=0 and mant=0 (either sign) -> out = 0, no flags.
REQ-020 (3) esum <= BIAS -> out = 0 (positive), unf=1.
REQ-021 (4) esum > 3*BIAS -> out = {s, 2^EXP_W-2, 2^MAN_W-2} (saturate), ovf=1; s = sa^sb.
REQ-022 (5) esum == 3*BIAS -> out = all-ones, nan=1.
REQ-023 (6) normal: product of {1,ma}x{1,mb} (2*MAN_W+2 bits); if MSB set shift right 1 and exp = esum-BIAS+1, else exp = esum-BIAS.
REQ-024 Rounding: truncate drops bits below mantissa LSB; RNE uses guard bit and OR of remaining bits, ties to even; mantissa carry-out SHALL increment exp and zero mant.
REQ-025 Normal-path exp reaching 2^EXP_W-1 after normalise/round SHALL saturate per REQ-021 with ovf=1.
REQ-026 Flags outside their case SHALL be 0; at most one flag set per result.

Reset
REQ-027 While rst_n=0: all stage valid bits 0, out_valid=0, in_ready=0, out_data=0, out_flags=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; none emerge after release.
REQ-029 in_ready SHALL go 1 on the first clk edge after rst_n release.

Configuration
REQ-030 Macro DLFLOAT_MUL_FLAGS_EN: defined -> out_flags port and flag pipeline registers exist per REQ-012/018-026; undefined -> port and registers removed, out_data/timing identical.

Verification
REQ-031 EXP_W=6, MAN_W=9, rnd_mode=0: 0x3E00*0x3E00 -> 0x3E00 at cycle 3; 0x3F00*0x3F00 -> 0x4040; flags 000.
REQ-032 Rounding tie: 0x3E01*0x3F00 -> 0x3F01 with rnd_mode=0, 0x3F02 with rnd_mode=1.
REQ-033 Specials: 0x7C00*0x7C00 -> 0x7DFE ovf; 0xFC00*0x7C00 -> 0xFDFE ovf; 0x1E00*0x2000 -> 0x0000 unf; 0xFFFF*0x3E00 -> 0xFFFF nan; 0x8000*0x7C00 -> 0x0000.
REQ-034 Backpressure: 6 back-to-back operands, out_ready=0 for 5 cycles -> in_ready drops after 3 accepted, all 6 results later emerge in order, out_data stable while stalled.
REQ-035 Reset with 3 results in flight -> out_valid=0 during and after reset, no stale result output; next operand yields correct result 3 cycles after acceptance.
REQ-036 Build without DLFLOAT_MUL_FLAGS_EN and rerun REQ-031..035 -> identical out_data sequences and cycle timing.

Source files
------------

// File: rtl/dlfloat_mul_pipe.sv
// dlfloat_mul_pipe -- three-stage pipelined DLFloat-style multiplier with
// valid/ready handshaking on both sides.
//
//   Stage p0 : operand classification and biased exponent sum
//   Stage p1 : significand multiply
//   Stage p2 : normalise, round (truncate or RNE), saturate and pack
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   operands accepted this cycle when in_valid is also high
//   in_a/in_b  operands {sign, exp[EXP_W], mant[MAN_W]}
//   rnd_mode   sampled with operands: 0 = truncate, 1 = round-to-nearest-even
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   product
//   out_flags  {nan, ovf, unf}; present only when DLFLOAT_MUL_FLAGS_EN is defined
//
// Optional feature macro: DLFLOAT_MUL_FLAGS_EN adds out_flags and its pipeline
// register. Without it out_data and timing are unchanged.
module dlfloat_mul_pipe #(
   parameter int EXP_W = 6,
   parameter int MAN_W = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic                   rnd_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_data
`ifdef DLFLOAT_MUL_FLAGS_EN
   ,
   output logic [2:0]             out_flags
`endif
);

   localparam int W        = 1 + EXP_W + MAN_W;
   localparam int PW       = 2 * MAN_W + 2;
   localparam int BIAS     = (1 << (EXP_W - 1)) - 1;
   localparam int TRI_BIAS = 3 * BIAS;
   localparam int EXP_SAT  = (1 << EXP_W) - 1;

   localparam logic [EXP_W:0]   BIAS_E     = BIAS[EXP_W:0];
   localparam logic [EXP_W:0]   TRI_BIAS_E = TRI_BIAS[EXP_W:0];
   localparam logic [EXP_W+1:0] BIAS_X     = BIAS[EXP_W+1:0];
   localparam logic [EXP_W+1:0] EXP_SAT_X  = EXP_SAT[EXP_W+1:0];

   typedef enum logic [2:0] {
      CLS_NORM,
      CLS_NAN,
      CLS_ZERO,
      CLS_UNF,
      CLS_OVF
   } cls_t;

   // Largest finite magnitude with the given sign.
   function automatic logic [W-1:0] sat_word(input logic s);
      return {s, {(EXP_W-1){1'b1}}, 1'b0, {(MAN_W-1){1'b1}}, 1'b0};
   endfunction

   // Returns {carry, mantissa}; the carry means the mantissa wrapped to 1.0.
   function automatic logic [MAN_W:0] round_mant(input logic [MAN_W-1:0] m,
                                                 input logic guard,
                                                 input logic sticky,
                                                 input logic rne);
      logic inc;
      inc = rne & guard & (sticky | m[0]);
      return {1'b0, m} + {{MAN_W{1'b0}}, inc};
   endfunction

   logic ready_en;
   logic vld_p0, vld_p1, vld_p2;
   logic en_p0, en_p1, en_p2;
   logic accept;

   // Each stage loads when it is empty or its content moves on this cycle.
   assign en_p2     = !vld_p2 | out_ready;
   assign en_p1     = !vld_p1 | en_p2;
   assign en_p0     = !vld_p0 | en_p1;
   assign in_ready  = ready_en & en_p0;
   assign accept    = in_valid & in_ready;
   assign out_valid = vld_p2;

   // ---- stage p0: classify, exponent sum ----
   logic [EXP_W:0] esum_c;
   cls_t           cls_c;
   logic           a_nan, b_nan, a_zero, b_zero;

   assign a_nan  = &in_a;
   assign b_nan  = &in_b;
   assign a_zero = (in_a[W-2 -: EXP_W] == '0) && (in_a[MAN_W-1:0] == '0);
   assign b_zero = (in_b[W-2 -: EXP_W] == '0) && (in_b[MAN_W-1:0] == '0);
   assign esum_c = {1'b0, in_a[W-2 -: EXP_W]} + {1'b0, in_b[W-2 -: EXP_W]};

   always_comb begin
      cls_c = CLS_NORM;
      if (a_nan || b_nan)              cls_c = CLS_NAN;
      else if (a_zero || b_zero)       cls_c = CLS_ZERO;
      else if (esum_c <= BIAS_E)       cls_c = CLS_UNF;
      else if (esum_c > TRI_BIAS_E)    cls_c = CLS_OVF;
      else if (esum_c == TRI_BIAS_E)   cls_c = CLS_NAN;
   end

   logic             sign_p0, rnd_p0;
   cls_t             cls_p0;
   logic [EXP_W:0]   esum_p0;
   logic [MAN_W-1:0] ma_p0, mb_p0;

   // ---- stage p1: significand multiply ----
   logic [PW-1:0]    sig_a, sig_b;
   logic             sign_p1, rnd_p1;
   cls_t             cls_p1;
   logic [EXP_W:0]   esum_p1;
   logic [PW-1:0]    prod_p1;

   assign sig_a = {{(MAN_W+1){1'b0}}, 1'b1, ma_p0};
   assign sig_b = {{(MAN_W+1){1'b0}}, 1'b1, mb_p0};

   always_ff @(posedge clk) begin
      if (accept) begin
         sign_p0 <= in_a[W-1] ^ in_b[W-1];
         cls_p0  <= cls_c;
         esum_p0 <= esum_c;
         ma_p0   <= in_a[MAN_W-1:0];
         mb_p0   <= in_b[MAN_W-1:0];
         rnd_p0  <= rnd_mode;
      end
      if (en_p1 && vld_p0) begin
         prod_p1 <= sig_a * sig_b;
         sign_p1 <= sign_p0;
         cls_p1  <= cls_p0;
         esum_p1 <= esum_p0;
         rnd_p1  <= rnd_p0;
      end
   end

   // ---- stage p2: normalise, round, pack ----
   logic [PW-2:0]    pn;
   logic [MAN_W:0]   mant_rnd;
   logic [EXP_W+1:0] exp_n;
   logic             norm_ovf;
   logic [W-1:0]     res_word;

   always_comb begin
      // Align so the leading 1 sits just above pn; guard/sticky follow the mantissa.
      pn       = prod_p1[PW-1] ? prod_p1[PW-2:0] : {prod_p1[PW-3:0], 1'b0};
      mant_rnd = round_mant(pn[PW-2 -: MAN_W], pn[PW-2-MAN_W], |pn[PW-3-MAN_W:0], rnd_p1);
      exp_n    = {1'b0, esum_p1} - BIAS_X
               + {{(EXP_W+1){1'b0}}, prod_p1[PW-1]}
               + {{(EXP_W+1){1'b0}}, mant_rnd[MAN_W]};
      norm_ovf = (exp_n >= EXP_SAT_X);
      res_word = '0;
      case (cls_p1)
         CLS_NAN:  res_word = '1;
         CLS_OVF:  res_word = sat_word(sign_p1);
         CLS_NORM: res_word = norm_ovf ? sat_word(sign_p1)
                                       : {sign_p1, exp_n[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
         default:  res_word = '0;
      endcase
   end

`ifdef DLFLOAT_MUL_FLAGS_EN
   logic [2:0] res_flags;
   assign res_flags = {cls_p1 == CLS_NAN,
                       (cls_p1 == CLS_OVF) || ((cls_p1 == CLS_NORM) && norm_ovf),
                       cls_p1 == CLS_UNF};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en  <= 1'b0;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         out_data  <= '0;
`ifdef DLFLOAT_MUL_FLAGS_EN
         out_flags <= '0;
`endif
      end else begin
         ready_en <= 1'b1;
         if (en_p0) vld_p0 <= accept;
         if (en_p1) vld_p1 <= vld_p0;
         if (en_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               out_data  <= res_word;
`ifdef DLFLOAT_MUL_FLAGS_EN
               out_flags <= res_flags;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_dlfloat_mul_pipe.sv
// Self-checking bench for dlfloat_mul_pipe (EXP_W=6, MAN_W=9).
// Directed vectors, backpressure, mid-flight reset and a randomized phase,
// with every accepted operand pair scored against a reference model.
module tb_dlfloat_mul_pipe;

   typedef struct packed {
      logic [2:0]  f;
      logic [15:0] d;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        rnd_mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
`ifdef DLFLOAT_MUL_FLAGS_EN
   logic [2:0]  out_flags;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   res_t exp_q[$];
   res_t exp_e;
   logic hold = 1'b0;
   logic [15:0] prev_data = '0;
   int   lat, acc, drop_at, cyc;
   logic [15:0] bp_a[6];
   logic [15:0] bp_b[6];

   dlfloat_mul_pipe #(.EXP_W(6), .MAN_W(9)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a(in_a),
      .in_b(in_b),
      .rnd_mode(rnd_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
`ifdef DLFLOAT_MUL_FLAGS_EN
      ,
      .out_flags(out_flags)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Reference: rules applied with plain integer arithmetic on real values.
   function automatic res_t ref_mul(input logic [15:0] a, input logic [15:0] b, input logic r);
      res_t   o;
      int     ea, eb, ma, mb, esum, e, k;
      longint p, q, rem, half, scale;
      logic   s;
      s  = a[15] ^ b[15];
      ea = int'(a[14:9]);
      eb = int'(b[14:9]);
      ma = int'(a[8:0]);
      mb = int'(b[8:0]);
      esum = ea + eb;
      o.f = 3'b000;
      o.d = 16'h0000;
      if (a == 16'hFFFF || b == 16'hFFFF) begin
         o.f = 3'b100; o.d = 16'hFFFF;
      end else if ((ea == 0 && ma == 0) || (eb == 0 && mb == 0)) begin
         o.d = 16'h0000;
      end else if (esum <= 31) begin
         o.f = 3'b001;
      end else if (esum > 93) begin
         o.f = 3'b010; o.d = {s, 6'd62, 9'd510};
      end else if (esum == 93) begin
         o.f = 3'b100; o.d = 16'hFFFF;
      end else begin
         p = longint'(512 + ma) * longint'(512 + mb);
         e = esum - 31;
         k = 9;
         if (p >= 64'sd524288) begin e++; k = 10; end
         scale = longint'(1) << k;
         q    = p / scale;
         rem  = p % scale;
         half = scale / 2;
         if (r && (rem > half || (rem == half && (q % 2) == 1))) q++;
         if (q == 1024) begin q = 512; e++; end
         if (e >= 63) begin
            o.f = 3'b010; o.d = {s, 6'd62, 9'd510};
         end else begin
            o.d = {s, 6'(e), 9'(q - 512)};
         end
      end
      return o;
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] v;
      int sel;
      v   = 16'($urandom);
      sel = int'($urandom_range(0, 19));
      if (sel < 14) v[14:9] = 6'($urandom_range(20, 46));
      if (sel == 18) v = 16'hFFFF;
      if (sel == 19) v[14:0] = '0;
      return v;
   endfunction

   // Scoreboard and hold-stability monitor.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold <= 1'b0;
      end else begin
         if (hold) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && out_ready) begin
            n_tests++;
            assert (exp_q.size() > 0) else begin
               n_fail++;
               $error("FAIL unexpected_result: got %0h want none", out_data);
            end
            if (exp_q.size() > 0) begin
               exp_e = exp_q.pop_front();
               check("data", 32'(out_data), 32'(exp_e.d));
`ifdef DLFLOAT_MUL_FLAGS_EN
               check("flags", 32'(out_flags), 32'(exp_e.f));
`endif
            end
         end
         if (in_valid && in_ready) exp_q.push_back(ref_mul(in_a, in_b, rnd_mode));
         hold      <= out_valid && !out_ready;
         prev_data <= out_data;
      end
   end

   task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic r, input logic [15:0] ed, input logic [2:0] ef);
      @(posedge clk); #1;
      in_a = a; in_b = b; rnd_mode = r; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      check({tag, "_latency"}, 32'(lat), 32'd3);
      check({tag, "_data"}, 32'(out_data), 32'(ed));
`ifdef DLFLOAT_MUL_FLAGS_EN
      check({tag, "_flags"}, 32'(out_flags), 32'(ef));
`else
      if (ef === 3'bxxx) check({tag, "_unused"}, 32'd0, 32'd1);
`endif
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
`ifdef DLFLOAT_MUL_FLAGS_EN
      check("rst_out_flags", 32'(out_flags), 32'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_before_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(in_ready), 32'd1);

      // Directed vectors
      run_single("one_x_one",  16'h3E00, 16'h3E00, 1'b0, 16'h3E00, 3'b000);
      run_single("1p5_sq",     16'h3F00, 16'h3F00, 1'b0, 16'h4040, 3'b000);
      run_single("tie_trunc",  16'h3E01, 16'h3F00, 1'b0, 16'h3F01, 3'b000);
      run_single("tie_rne",    16'h3E01, 16'h3F00, 1'b1, 16'h3F02, 3'b000);
      run_single("ovf_pos",    16'h7C00, 16'h7C00, 1'b0, 16'h7DFE, 3'b010);
      run_single("ovf_neg",    16'hFC00, 16'h7C00, 1'b0, 16'hFDFE, 3'b010);
      run_single("unf",        16'h1E00, 16'h2000, 1'b0, 16'h0000, 3'b001);
      run_single("unf_edge",   16'h1E00, 16'h2200, 1'b0, 16'h0200, 3'b000);
      run_single("nan_in",     16'hFFFF, 16'h3E00, 1'b0, 16'hFFFF, 3'b100);
      run_single("zero_neg",   16'h8000, 16'h7C00, 1'b0, 16'h0000, 3'b000);
      run_single("esum_3bias", 16'h3E00, 16'h7C00, 1'b0, 16'hFFFF, 3'b100);
      run_single("carry_rne",  16'h3ED4, 16'h3ED4, 1'b1, 16'h4000, 3'b000);
      run_single("carry_trc",  16'h3ED4, 16'h3ED4, 1'b0, 16'h3FFF, 3'b000);

      // Backpressure: six back-to-back operands, out_ready low for five cycles
      for (int i = 0; i < 6; i++) begin
         bp_a[i] = rand_op();
         bp_b[i] = rand_op();
      end
      acc = 0; drop_at = -1; cyc = 0;
      while (acc < 6 && cyc < 40) begin
         @(posedge clk); #1;
         out_ready = (cyc >= 5);
         in_valid  = 1'b1;
         in_a      = bp_a[acc];
         in_b      = bp_b[acc];
         rnd_mode  = acc[0];
         @(negedge clk);
         if (in_ready) acc++;
         else if (drop_at < 0) drop_at = acc;
         cyc++;
      end
      check("bp_accepted", 32'(acc), 32'd6);
      check("bp_drop_after", 32'(drop_at), 32'd3);
      drain("bp_drain");

      // Reset with three results in flight
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         out_ready = 1'b0; in_valid = 1'b1;
         in_a = rand_op(); in_b = rand_op(); rnd_mode = 1'b0;
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_out_valid", 32'(out_valid), 32'd0);
      end
      run_single("post_rst", 16'h3F00, 16'h3F00, 1'b0, 16'h4040, 3'b000);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_a      = rand_op();
         in_b      = rand_op();
         rnd_mode  = 1'($urandom_range(0, 1));
      end
      drain("rand_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
